// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with direct-select or round-robin arbitration
// Ports: clk, rst_n (async active-low); mode (0 = direct via sel, 1 = round-robin), sel;
//        in_valid/in_data/in_last/in_ready per channel; out_valid/out_data/out_ch/out_last
//        from a single-entry output register, out_ready from the consumer.
// Optional: define STREAM_MUX_LAST_LOCK_EN to hold the round-robin grant on a channel until in_last.
module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_last,
  input  logic                  out_ready
);
  logic [SEL_W-1:0] g, last_ch;
  logic gv, can_load, accept;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic locked;
  logic [SEL_W-1:0] lock_ch;
`endif
  // Round-robin scan runs from farthest to nearest so the channel right after last_ch wins.
  always_comb begin
    g = '0;
    gv = 1'b0;
    if (!mode) begin
      for (int c = 0; c < N_CH; c++)
        if (sel == SEL_W'(c) && in_valid[c]) begin
          g = sel;
          gv = 1'b1;
        end
    end else begin
      for (int i = N_CH; i >= 1; i--)
        if (in_valid[(int'(last_ch) + i) % N_CH]) begin
          g = SEL_W'((int'(last_ch) + i) % N_CH);
          gv = 1'b1;
        end
`ifdef STREAM_MUX_LAST_LOCK_EN
      if (locked) begin
        g = lock_ch;
        gv = in_valid[lock_ch];
      end
`endif
    end
  end
  assign can_load = !out_valid | out_ready;
  // rst_n gates the handshake so no beat is offered while reset is asserted.
  assign accept = gv & can_load & rst_n;
  assign in_ready = {{(N_CH-1){1'b0}}, accept} << g;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      last_ch <= SEL_W'(N_CH - 1);
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= in_data[int'(g)*WIDTH +: WIDTH];
        out_ch <= g;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && mode) last_ch <= g;
    end
  end
`ifdef STREAM_MUX_LAST_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last <= 1'b0;
      locked <= 1'b0;
      lock_ch <= '0;
    end else begin
      if (accept) out_last <= in_last[g];
      if (!mode) begin
        locked <= 1'b0;
      end else if (accept) begin
        locked <= !in_last[g];
        lock_ch <= g;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign out_last = 1'b0;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed self-checking bench for stream_mux_rr (4-channel and 3-channel instances)
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0] in_last = '0;
  logic [3:0] in_ready;
  logic out_valid;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic out_last;
  logic out_ready = 1'b0;
  logic b_mode = 1'b0;
  logic [1:0] b_sel = '0;
  logic [2:0] b_in_valid = '0;
  logic [23:0] b_in_data = '0;
  logic [2:0] b_in_last = '0;
  logic [2:0] b_in_ready;
  logic b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_out_ch;
  logic b_out_last;
  logic b_out_ready = 1'b0;
  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ch(b_out_ch), .out_last(b_out_last), .out_ready(b_out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    mode = 1'b0; sel = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    vecs++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vecs++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tick;
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[7:0] = 8'h5A; out_ready = 1'b0;
    tick;
    vecs++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin fails++; $display("FAIL pre_reset_load: got %b/%h expected 1/5a", out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    vecs++; if (out_data !== 8'h00) begin fails++; $display("FAIL async_reset_data: got %h expected 00", out_data); end
    vecs++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL async_reset_ready: got %b expected 0000", in_ready); end
    in_valid = '0;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    vecs++; if ({out_valid, out_data, out_ch, out_last, in_ready} !== 16'h0000) begin fails++; $display("FAIL idle_after_reset: got %b/%h/%0d/%b/%b expected all 0", out_valid, out_data, out_ch, out_last, in_ready); end
  endtask

  task automatic test_direct;
    do_reset;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h3C_A5_21_10; out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL direct_ready: got %b expected 0100", in_ready); end
    tick;
    vecs++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin fails++; $display("FAIL direct_beat: got %b/%h/%0d expected 1/a5/2", out_valid, out_data, out_ch); end
    sel = 2'd3;
    #1;
    vecs++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL direct_ready_sel3: got %b expected 1000", in_ready); end
    tick;
    vecs++; if (out_data !== 8'h3C || out_ch !== 2'd3) begin fails++; $display("FAIL direct_sel3_beat: got %h/%0d expected 3c/3", out_data, out_ch); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ch;
    do_reset;
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'hC3_C2_C1_C0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      exp_ch = 2'(k % 4);
      vecs++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== 8'hC0 + 8'(exp_ch)) begin fails++; $display("FAIL rr_all_%0d: got %b/%0d/%h expected 1/%0d/%h", k, out_valid, out_ch, out_data, exp_ch, 8'hC0 + 8'(exp_ch)); end
    end
    do_reset;
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
      vecs++; if (out_ch !== exp_ch) begin fails++; $display("FAIL rr_sparse_%0d: got %0d expected %0d", k, out_ch, exp_ch); end
    end
  endtask

  task automatic test_back_pressure;
    do_reset;
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0011; out_ready = 1'b0;
    tick;
    vecs++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin fails++; $display("FAIL bp_latch: got %b/%h expected 1/11", out_valid, out_data); end
    in_data[7:0] = 8'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready_%0d: got %b expected 0000", k, in_ready); end
      tick;
      vecs++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin fails++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/11", k, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b expected 0001", in_ready); end
    tick;
    vecs++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin fails++; $display("FAIL bp_no_bubble: got %b/%h expected 1/22", out_valid, out_data); end
    in_valid = '0;
    tick;
    vecs++; if (out_valid !== 1'b0 || out_data !== 8'h22 || out_ch !== 2'd0) begin fails++; $display("FAIL drain: got %b/%h/%0d expected 0/22/0", out_valid, out_data, out_ch); end
  endtask

  task automatic test_invalid_sel;
    b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_in_data = 24'h77_66_55; b_out_ready = 1'b1;
    #1;
    vecs++; if (b_in_ready !== 3'b000) begin fails++; $display("FAIL invalid_sel_ready: got %b expected 000", b_in_ready); end
    tick;
    tick;
    vecs++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL invalid_sel_valid: got %b expected 0", b_out_valid); end
    b_sel = 2'd1;
    #1;
    vecs++; if (b_in_ready !== 3'b010) begin fails++; $display("FAIL sel1_ready_n3: got %b expected 010", b_in_ready); end
    tick;
    vecs++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h66 || b_out_ch !== 2'd1) begin fails++; $display("FAIL sel1_beat_n3: got %b/%h/%0d expected 1/66/1", b_out_valid, b_out_data, b_out_ch); end
    b_in_valid = '0;
  endtask

  task automatic test_lock;
    logic [1:0] exp_ch [4];
    logic exp_last [4];
    logic lasts [4];
`ifdef STREAM_MUX_LAST_LOCK_EN
    exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_ch = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    lasts = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset;
    mode = 1'b1; in_valid = 4'b0011; out_ready = 1'b1; in_data = 32'h0000_E100;
    for (int k = 0; k < 4; k++) begin
      in_last = {3'b000, lasts[k]};
      in_data[7:0] = 8'hD0 + 8'(k);
      tick;
      vecs++; if (out_ch !== exp_ch[k] || out_last !== exp_last[k]) begin fails++; $display("FAIL lock_%0d: got ch%0d/last%b expected ch%0d/last%b", k, out_ch, out_last, exp_ch[k], exp_last[k]); end
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset;
    test_direct;
    test_round_robin;
    test_back_pressure;
    test_invalid_sel;
    test_lock;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
